// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target controller.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StWaitStop
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the CLK domain and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], scl_i};
    sda_d = {sda_q[1:0], sda_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_q <= '0;
      sda_q <= '0;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  // Bit 1 is the synchronized level, bit 2 its previous value.
  logic scl_high;
  assign scl_high   = scl_q[1] & scl_q[2];
  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = ~sda_q[1] & sda_q[2] & scl_high;
  assign stop_o     = sda_q[1] & ~sda_q[2] & scl_high;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target: address match, write-byte receive and read-byte transmit, no clock stretching.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLV_ADDR = 7'h2A
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SCL,
  input  logic                  SDA_in,
  output logic                  SDA_oe,
  output logic [I2C_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [I2C_DATA_W-1:0] tx_data,
  output logic                  tx_req,
  output logic                  nack_rcvd,
  output logic                  busy,
  output logic                  rd_mode
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .clk_i      (CLK),
    .rst_i      (RST),
    .scl_i      (SCL),
    .sda_i      (SDA_in),
    .sda_o      (sda),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  i2c_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_DATA_W-1:0] shift_q, shift_d;
  logic [I2C_DATA_W-1:0] rx_data_q, rx_data_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_req_q, tx_req_d;
  logic                  nack_q, nack_d;
  logic                  busy_q, busy_d;
  logic                  rd_mode_q, rd_mode_d;
  // Marks "byte done, ACK phase pending" in WR_DATA and "master ACKed" in RD_ACK.
  logic                  byte_done_q, byte_done_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rd_mode_d   = rd_mode_q;
    byte_done_d = byte_done_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    nack_d      = 1'b0;

    if (stop) begin
      state_d     = StIdle;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
    end else if (start) begin
      state_d     = StAddr;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d   = {shift_q[I2C_DATA_W-2:0], sda};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_q[I2C_ADDR_W-1:0] == SLV_ADDR) begin
                busy_d    = 1'b1;
                rd_mode_d = sda;
                tx_req_d  = sda;
                state_d   = StAddrAck;
              end else begin
                state_d = StWaitStop;
              end
            end
          end
        end
        StAddrAck: begin
          // First fall drives the ACK, second fall ends it.
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rd_mode_q) begin
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[I2C_DATA_W-1];
              state_d  = StRdData;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StWrData;
            end
          end
        end
        StWrData: begin
          if (scl_rise) begin
            shift_d   = {shift_q[I2C_DATA_W-2:0], sda};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d   = {shift_q[I2C_DATA_W-2:0], sda};
              rx_valid_d  = 1'b1;
              byte_done_d = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            sda_oe_d    = 1'b1;
            byte_done_d = 1'b0;
            state_d     = StWrAck;
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = StWrData;
          end
        end
        StRdData: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d    = 1'b0;
              bit_cnt_d   = '0;
              byte_done_d = 1'b0;
              state_d     = StRdAck;
            end else begin
              shift_d   = {shift_q[I2C_DATA_W-2:0], 1'b0};
              sda_oe_d  = ~shift_q[I2C_DATA_W-2];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (!sda) begin
              tx_req_d    = 1'b1;
              byte_done_d = 1'b1;
            end else begin
              nack_d  = 1'b1;
              state_d = StWaitStop;
            end
          end else if (scl_fall && byte_done_q) begin
            shift_d     = tx_data;
            sda_oe_d    = ~tx_data[I2C_DATA_W-1];
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            state_d     = StRdData;
          end
        end
        StIdle, StWaitStop: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      sda_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      nack_q      <= 1'b0;
      busy_q      <= 1'b0;
      rd_mode_q   <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      sda_oe_q    <= sda_oe_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      nack_q      <= nack_d;
      busy_q      <= busy_d;
      rd_mode_q   <= rd_mode_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign SDA_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign nack_rcvd = nack_q;
  assign busy      = busy_q;
  assign rd_mode   = rd_mode_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench: an open-drain bus master model drives i2c_slave_ctrl (SLV_ADDR 7'h2A).
module tb_i2c_slave_ctrl;
  import i2c_pkg::*;

  localparam int CLK_HALF = 10;   // 50 MHz
  localparam int Q        = 625;  // quarter SCL period

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SCL = 1'b1;
  logic       sda_m = 1'b1;
  logic       SDA_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       nack_rcvd;
  logic       busy;
  logic       rd_mode;
  logic       sda_bus;

  assign sda_bus = sda_m & ~SDA_oe;

  i2c_slave_ctrl #(.SLV_ADDR(7'h2A)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SCL       (SCL),
    .SDA_in    (sda_bus),
    .SDA_oe    (SDA_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .nack_rcvd (nack_rcvd),
    .busy      (busy),
    .rd_mode   (rd_mode)
  );

  always #CLK_HALF CLK = ~CLK;

  // Event monitors: cumulative counts, read as deltas by the stimulus.
  int         rx_cnt = 0, txr_cnt = 0, nack_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic [7:0] rx_log [0:31];

  always @(posedge CLK) begin
    if (rx_valid) begin
      if (rx_cnt < 32) rx_log[rx_cnt] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_req)    txr_cnt  <= txr_cnt + 1;
    if (nack_rcvd) nack_cnt <= nack_cnt + 1;
    if (SDA_oe)    oe_cnt   <= oe_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #Q;
    SCL = 1'b1;   #Q;
    sda_m = 1'b0; #Q;
    SCL = 1'b0;   #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    SCL = 1'b1;   #Q;
    sda_m = 1'b1; #Q;
    #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q;
    SCL = 1'b1; #Q;
    #Q;
    SCL = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q;
    SCL = 1'b1;   #Q;
    b = sda_bus;  #Q;
    SCL = 1'b0;   #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    ack = ~a;
  endtask

  task automatic read_byte(input logic ack, input logic [7:0] next_tx, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    tx_data = next_tx;
    write_bit(~ack);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] d1, d2;
    int         rx0, txr0, nack0, oe0, busy0;

    repeat (5) @(posedge CLK);
    #1;
    check("rst_sda_oe", SDA_oe, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_rd_mode", rd_mode, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req", tx_req, 0);
    RST = 1'b0;
    #(4 * Q);

    // Write two bytes to our address.
    rx0 = rx_cnt;
    bus_start();
    write_byte(8'h54, ack); check("wr_addr_ack", ack, 1);
    write_byte(8'hA5, ack); check("wr_b1_ack", ack, 1);
    write_byte(8'h3C, ack); check("wr_b2_ack", ack, 1);
    check("wr_busy_mid", busy, 1);
    bus_stop();
    #(2 * Q);
    check("wr_rx_count", rx_cnt - rx0, 2);
    check("wr_rx_b1", rx_log[rx0], 8'hA5);
    check("wr_rx_b2", rx_log[rx0 + 1], 8'h3C);
    check("wr_busy_after_stop", busy, 0);

    // Foreign address: block stays silent.
    rx0 = rx_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
    bus_start();
    write_byte(8'h56, ack); check("miss_addr_nack", ack, 0);
    write_byte(8'h11, ack); check("miss_data_nack", ack, 0);
    bus_stop();
    #(2 * Q);
    check("miss_oe_cycles", oe_cnt - oe0, 0);
    check("miss_rx_count", rx_cnt - rx0, 0);
    check("miss_busy_cycles", busy_cnt - busy0, 0);

    // Read two bytes, ACK then NACK.
    txr0 = txr_cnt; nack0 = nack_cnt;
    tx_data = 8'hC3;
    bus_start();
    write_byte(8'h55, ack); check("rd_addr_ack", ack, 1);
    check("rd_rd_mode", rd_mode, 1);
    read_byte(1'b1, 8'h81, d1); check("rd_byte1", d1, 8'hC3);
    read_byte(1'b0, 8'h00, d2); check("rd_byte2", d2, 8'h81);
    #Q;
    check("rd_tx_req_count", txr_cnt - txr0, 2);
    check("rd_nack_count", nack_cnt - nack0, 1);
    check("rd_sda_released", SDA_oe, 0);
    bus_stop();

    // Write one byte, repeated START, read one byte.
    rx0 = rx_cnt;
    tx_data = 8'h5A;
    bus_start();
    write_byte(8'h54, ack); check("rs_wr_addr_ack", ack, 1);
    check("rs_rd_mode_wr", rd_mode, 0);
    write_byte(8'h11, ack); check("rs_wr_data_ack", ack, 1);
    bus_start();
    write_byte(8'h55, ack); check("rs_rd_addr_ack", ack, 1);
    check("rs_rd_mode_rd", rd_mode, 1);
    read_byte(1'b0, 8'h00, d1); check("rs_rd_byte", d1, 8'h5A);
    bus_stop();
    #(2 * Q);
    check("rs_rx_count", rx_cnt - rx0, 1);
    check("rs_rx_value", rx_log[rx0], 8'h11);

    // Reset while driving a 0 data bit, then a clean write.
    tx_data = 8'hC3;
    bus_start();
    write_byte(8'h55, ack); check("rst_mid_addr_ack", ack, 1);
    read_bit(d1[7]);
    read_bit(d1[6]);
    check("rst_mid_oe_before", SDA_oe, 1);
    @(posedge CLK);
    #3 RST = 1'b1;
    #1 check("rst_mid_oe_same_cycle", SDA_oe, 0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    sda_m = 1'b1; #Q;
    SCL = 1'b1;   #(2 * Q);
    rx0 = rx_cnt;
    bus_start();
    write_byte(8'h54, ack); check("post_rst_addr_ack", ack, 1);
    write_byte(8'h77, ack); check("post_rst_data_ack", ack, 1);
    bus_stop();
    #(2 * Q);
    check("post_rst_rx_count", rx_cnt - rx0, 1);
    check("post_rst_rx_value", rx_log[rx0], 8'h77);

    // Partial byte cut off by STOP.
    rx0 = rx_cnt;
    bus_start();
    write_byte(8'h54, ack); check("part_addr_ack", ack, 1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    bus_stop();
    #(2 * Q);
    check("part_rx_count", rx_cnt - rx0, 0);
    check("part_state_idle", dut.state_q, StIdle);
    check("part_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
